// File: rtl/stopwatch_time_counter.sv
// rtl/stopwatch_time_counter.sv - run/stop/clear FSM driving cascaded msec/sec/min/hour counters
// Optional lap freeze of o_data is built when STOPWATCH_LAP_EN is defined.
module stopwatch_time_counter #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_run_stop,
  input  logic        i_clear,
  input  logic        i_lap,
  output logic [23:0] o_data,
  output logic        o_running,
  output logic        o_lap_active
);
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int DW  = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX  = DW'(DIV - 1);
  localparam logic [6:0]    MSEC_MAX = 7'(TICK_HZ - 1);

  if (TICK_HZ > 128 || DIV < 2) begin : g_param_check
    $error("stopwatch_time_counter: TICK_HZ must be <= 128 and CLK_FREQ/TICK_HZ >= 2");
  end

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t state, state_n;
  logic   run_n, tick, clear_entry;

  logic [DW-1:0] div_cnt, div_n;
  logic [4:0]    hour_q, hour_n;
  logic [5:0]    min_q, min_n;
  logic [5:0]    sec_q, sec_n;
  logic [6:0]    msec_q, msec_n;
  logic [23:0]   live_q, live_n, display_n;

  assign live_q = {hour_q, min_q, sec_q, msec_q};
  assign live_n = {hour_n, min_n, sec_n, msec_n};

  // o_running is registered from the next state so it changes on the entering edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_STOP;
      o_running <= 1'b0;
    end else begin
      state     <= state_n;
      o_running <= run_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_STOP: begin
        if (i_clear)         state_n = ST_CLEAR;
        else if (i_run_stop) state_n = ST_RUN;
      end
      ST_RUN:   if (i_run_stop) state_n = ST_STOP;
      ST_CLEAR: state_n = ST_STOP;
      default:  state_n = ST_STOP;
    endcase
  end

  always_comb begin
    run_n       = (state_n == ST_RUN);
    tick        = (state == ST_RUN) && (div_cnt == DIV_MAX);
    clear_entry = (state == ST_STOP) && i_clear;
  end

  // Whole carry chain resolves on the tick edge; divider holds outside RUN
  always_comb begin
    div_n  = div_cnt;
    hour_n = hour_q;
    min_n  = min_q;
    sec_n  = sec_q;
    msec_n = msec_q;
    if (clear_entry) begin
      div_n  = '0;
      hour_n = '0;
      min_n  = '0;
      sec_n  = '0;
      msec_n = '0;
    end else if (state == ST_RUN) begin
      if (!tick) begin
        div_n = div_cnt + DW'(1);
      end else begin
        div_n = '0;
        if (msec_q != MSEC_MAX) begin
          msec_n = msec_q + 7'd1;
        end else begin
          msec_n = '0;
          if (sec_q != 6'd59) begin
            sec_n = sec_q + 6'd1;
          end else begin
            sec_n = '0;
            if (min_q != 6'd59) begin
              min_n = min_q + 6'd1;
            end else begin
              min_n  = '0;
              hour_n = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end
          end
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [23:0] lap_q, lap_n;
  logic        lap_active_n;

  always_comb begin
    lap_n        = lap_q;
    lap_active_n = o_lap_active;
    if (clear_entry) begin
      lap_n        = '0;
      lap_active_n = 1'b0;
    end else if (state == ST_RUN && i_lap) begin
      if (o_lap_active) begin
        lap_active_n = 1'b0;
      end else begin
        lap_n        = live_q;
        lap_active_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q        <= '0;
      o_lap_active <= 1'b0;
    end else begin
      lap_q        <= lap_n;
      o_lap_active <= lap_active_n;
    end
  end

  assign display_n = lap_active_n ? lap_n : live_n;
`else
  logic unused_lap;
  assign unused_lap   = i_lap;
  assign o_lap_active = 1'b0;
  assign display_n    = live_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      msec_q  <= '0;
      o_data  <= '0;
    end else begin
      div_cnt <= div_n;
      hour_q  <= hour_n;
      min_q   <= min_n;
      sec_q   <= sec_n;
      msec_q  <= msec_n;
      o_data  <= display_n;
    end
  end

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// tb/tb_stopwatch_time_counter.sv - randomized and directed checks of stopwatch_time_counter against an elapsed-cycle model
module tb_stopwatch_time_counter;
  localparam int CLK_FREQ = 1000;
  localparam int TICK_HZ  = 100;
  localparam int DIV      = CLK_FREQ / TICK_HZ;
  localparam longint DAY  = 64'd8640000;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0, i_run_stop = 1'b0, i_clear = 1'b0, i_lap = 1'b0;
  logic [23:0] o_data;
  logic        o_running, o_lap_active;

  int n_pass = 0;
  int n_total = 0;

  // Model: time is simply (number of edges spent in RUN since clear) / DIV ticks
  longint      run_edges = 0;
  bit          m_running = 0, m_clr = 0, m_lap = 0;
  logic [23:0] m_lap_val = '0;

  stopwatch_time_counter #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .reset(reset), .i_run_stop(i_run_stop), .i_clear(i_clear),
    .i_lap(i_lap), .o_data(o_data), .o_running(o_running), .o_lap_active(o_lap_active)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] time_word(input longint edges);
    longint t;
    t = (edges / DIV) % DAY;
    return {5'(t / 360000), 6'((t / 6000) % 60), 6'((t / 100) % 60), 7'(t % 100)};
  endfunction

  function automatic logic [25:0] expected();
    return {(m_lap ? m_lap_val : time_word(run_edges)), m_running, m_lap};
  endfunction

  task automatic cycle();
    logic [23:0] cur;
    @(posedge clk);
    cur = time_word(run_edges);
    if (reset) begin
      run_edges = 0; m_running = 0; m_clr = 0; m_lap = 0; m_lap_val = '0;
    end else if (m_clr) begin
      m_clr = 0;
    end else if (m_running) begin
      if (LAP_EN && i_lap) begin
        if (m_lap) m_lap = 0;
        else begin m_lap = 1; m_lap_val = cur; end
      end
      run_edges++;
      if (i_run_stop) m_running = 0;
    end else if (i_clear) begin
      run_edges = 0; m_clr = 1; m_lap = 0; m_lap_val = '0;
    end else if (i_run_stop) begin
      m_running = 1;
    end
    #1;
    reset = 0; i_run_stop = 0; i_clear = 0; i_lap = 0;
  endtask

  task automatic test_reset();
    reset = 1; cycle();
    n_total++;
    if ({o_data, o_running, o_lap_active} !== 26'h0) $display("FAIL reset_state got=%h want=0", {o_data, o_running, o_lap_active});
    else n_pass++;
  endtask

  task automatic test_count();
    i_run_stop = 1; cycle();
    n_total++;
    if (o_running !== 1'b1 || o_data !== 24'h0) $display("FAIL run_entry run=%b data=%h want run=1 data=000000", o_running, o_data);
    else n_pass++;
    repeat (9) cycle();
    n_total++;
    if (o_data !== 24'h000000) $display("FAIL before_first_tick data=%h want=000000", o_data);
    else n_pass++;
    cycle();
    n_total++;
    if (o_data !== 24'h000001) $display("FAIL first_tick data=%h want=000001", o_data);
    else n_pass++;
    repeat (10) cycle();
    n_total++;
    if (o_data !== 24'h000002) $display("FAIL second_tick data=%h want=000002", o_data);
    else n_pass++;
  endtask

  task automatic test_wrap();
    reset = 1; cycle();
    force dut.hour_q = 5'd23;
    force dut.min_q  = 6'd59;
    force dut.sec_q  = 6'd59;
    force dut.msec_q = 7'd99;
    cycle();
    release dut.hour_q;
    release dut.min_q;
    release dut.sec_q;
    release dut.msec_q;
    run_edges = (DAY - 1) * DIV;
    i_run_stop = 1; cycle();
    repeat (9) cycle();
    n_total++;
    if (o_data !== 24'hBF7DE3 || o_data !== time_word(run_edges)) $display("FAIL wrap_pre data=%h want=bf7de3", o_data);
    else n_pass++;
    cycle();
    n_total++;
    if (o_data !== 24'h000000 || o_running !== 1'b1) $display("FAIL wrap data=%h run=%b want data=000000 run=1", o_data, o_running);
    else n_pass++;
  endtask

  task automatic test_pause();
    int k;
    reset = 1; cycle();
    i_run_stop = 1; cycle();
    repeat (3) cycle();
    i_run_stop = 1; cycle();
    n_total++;
    if (o_running !== 1'b0 || o_data !== 24'h0) $display("FAIL pause_stop run=%b data=%h want run=0 data=000000", o_running, o_data);
    else n_pass++;
    repeat (50) cycle();
    n_total++;
    if (o_data !== 24'h0 || o_running !== 1'b0) $display("FAIL pause_hold data=%h run=%b want data=000000 run=0", o_data, o_running);
    else n_pass++;
    i_run_stop = 1; cycle();
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (o_data != 24'h0) begin k = i; break; end
    end
    n_total++;
    if (k != 6 || o_data !== 24'h000001) $display("FAIL resume_latency cycles=%0d data=%h want cycles=6 data=000001", k, o_data);
    else n_pass++;
  endtask

  task automatic test_clear();
    repeat (17) cycle();
    i_clear = 1; cycle();
    n_total++;
    if ({o_data, o_running, o_lap_active} !== expected() || o_data == 24'h0) $display("FAIL clear_in_run got=%h want=%h", {o_data, o_running, o_lap_active}, expected());
    else n_pass++;
    i_run_stop = 1; cycle();
    i_clear = 1; i_run_stop = 1; cycle();
    n_total++;
    if (o_data !== 24'h0 || o_running !== 1'b0) $display("FAIL clear_priority data=%h run=%b want data=000000 run=0", o_data, o_running);
    else n_pass++;
    i_run_stop = 1; cycle();
    n_total++;
    if (o_data !== 24'h0 || o_running !== 1'b0) $display("FAIL clear_ignores_input data=%h run=%b want data=000000 run=0", o_data, o_running);
    else n_pass++;
    i_run_stop = 1; cycle();
    repeat (DIV) cycle();
    n_total++;
    if (o_data !== 24'h000001 || o_running !== 1'b1) $display("FAIL after_clear_run data=%h run=%b want data=000001 run=1", o_data, o_running);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    reset = 1; cycle();
    i_run_stop = 1; cycle();
    repeat (500 * DIV) cycle();
    n_total++;
    if (o_data !== 24'h000280) $display("FAIL five_seconds data=%h want=000280", o_data);
    else n_pass++;
    reset = 1; cycle();
    n_total++;
    if (o_data !== 24'h0 || o_running !== 1'b0) $display("FAIL reset_midrun data=%h run=%b want data=000000 run=0", o_data, o_running);
    else n_pass++;
    repeat (30) cycle();
    n_total++;
    if (o_data !== 24'h0 || o_running !== 1'b0) $display("FAIL reset_stays_stopped data=%h run=%b want data=000000 run=0", o_data, o_running);
    else n_pass++;
  endtask

  task automatic test_lap();
    reset = 1; cycle();
    i_run_stop = 1; cycle();
    repeat (30 * DIV) cycle();
    i_lap = 1; cycle();
    n_total++;
    if (o_data !== 24'h00001E || o_lap_active !== LAP_EN) $display("FAIL lap_capture data=%h lap=%b want data=00001e lap=%b", o_data, o_lap_active, LAP_EN);
    else n_pass++;
    repeat (200) cycle();
    n_total++;
    if ({o_data, o_running, o_lap_active} !== expected()) $display("FAIL lap_hold got=%h want=%h", {o_data, o_running, o_lap_active}, expected());
    else n_pass++;
`ifdef STOPWATCH_LAP_EN
    n_total++;
    if (o_data !== 24'h00001E || o_lap_active !== 1'b1) $display("FAIL lap_frozen data=%h lap=%b want data=00001e lap=1", o_data, o_lap_active);
    else n_pass++;
    i_lap = 1; cycle();
    n_total++;
    if (o_data !== 24'h000032 || o_lap_active !== 1'b0) $display("FAIL lap_release data=%h lap=%b want data=000032 lap=0", o_data, o_lap_active);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    reset = 1; cycle();
    for (int i = 0; i < 4000; i++) begin
      i_run_stop = ($urandom_range(0, 15) == 0);
      i_clear    = ($urandom_range(0, 23) == 0);
      i_lap      = ($urandom_range(0, 19) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      cycle();
      n_total++;
      if ({o_data, o_running, o_lap_active} !== expected()) begin
        if (errs < 10) $display("FAIL random cyc=%0d got=%h want=%h", i, {o_data, o_running, o_lap_active}, expected());
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_pause();
    test_clear();
    test_reset_midrun();
    test_lap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
